lat_mem: RTL and testbench
==========================

# lat_mem

Parametrised single-port data memory with a valid/ready request handshake, configurable access latency and error reporting. It replaces the fixed one-cycle byte-array memory in the hart bench and serves as the data or instruction memory model for stall-tolerant hart revisions. It is synthesizable, supports byte-masked little-endian writes, and allows one outstanding request.

## Interface
Parameters:
- ADDR_WIDTH, 10, byte-address bits; the array holds 2^ADDR_WIDTH bytes.
- LATENCY, 1, cycles from request accept to response; legal range 1..8.
- BASE_ADDR, 32'h0, first byte address mapped to array byte 0; must be word aligned.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  block can accept a request this cycle.
- i_addr  in  32  byte address of the access.
- i_ren  in  1  read request.
- i_wen  in  1  write request.
- i_wdata  in  32  write data, lane n = bits [8n+7:8n].
- i_mask  in  4  byte-lane enables; bit n selects byte i_addr+n.
- o_rsp_valid  out  1  response valid, one cycle per accepted request.
- o_rdata  out  32  read data; meaningful only while o_rsp_valid is high.
- o_err  out  1  request rejected; meaningful only while o_rsp_valid is high.

## Operation
- States: IDLE, BUSY, RESP.
- Accept: a request is accepted when i_req_valid & o_req_ready is high at a rising edge.
- o_req_ready = (state != BUSY).
- On accept, the block captures addr, ren, wen, wdata and mask.
- IDLE/RESP to BUSY: on accept with LATENCY > 1. The latency counter loads LATENCY-1.
- IDLE/RESP to RESP: on accept with LATENCY == 1.
- BUSY: the counter decrements each cycle. At count 1 the block moves to RESP.
- RESP to IDLE: when there is no accept in the RESP cycle.
- Completion happens at the edge that enters RESP. The block evaluates the captured request there:
  - Error if offset = addr - BASE_ADDR satisfies offset >= 2^ADDR_WIDTH (unsigned).
  - Error if addr[1:0] != 0.
  - Error if ren & wen are both set.
- On error: o_err=1, o_rdata=0, no array write.
- Read: o_rdata lane n = mem[offset+n] when mask[n]=1, else 8'h00.
- Write: mem[offset+n] <= wdata lane n for each mask[n]=1. o_rdata=0.
- Neither ren nor wen set: the request is acknowledged with o_err=0 and o_rdata=0.
- mask=0 is not an error; the read returns 0 and the write changes nothing.
- Ordering: a read accepted after a write always returns the written bytes, because there is one outstanding request and the write commits before the next accept can complete.
- Array contents are not reset and power up as X.

## Timing
- Reset values while i_rst is high and immediately after:
  - state=IDLE, o_req_ready=1, o_rsp_valid=0, o_rdata=0, o_err=0, counter=0.
- Reset mid-operation: the pending request is dropped, no write commits, and no response is issued.
- Latency: a request accepted at edge T gets its response valid for exactly the cycle after edge T+LATENCY-1.
  - With LATENCY=1 the response is in the cycle right after accept. This matches the legacy bench memory timing.
- Throughput: a new accept is allowed in the RESP cycle, so back-to-back requests complete every LATENCY cycles.
  - With LATENCY=1, o_req_ready stays high continuously.
- o_rsp_valid is high for exactly one cycle per accepted request and never without an accept.
- Inputs other than i_req_valid are don't-care when the request is not accepted.
- The block drops requests that arrive while ready is low, so the requester must hold them until accepted.

## Test plan
- LATENCY=1, BASE_ADDR=0:
  - Write addr 0x10, wdata 0xDEADBEEF, mask 1111 -> o_rsp_valid in the next cycle, o_err=0.
  - Then read 0x10, mask 1111 -> o_rdata=0xDEADBEEF one cycle after accept.
- Byte mask:
  - Write 0x20 with 0x11223344, mask 1111.
  - Then write 0xAABBCCDD, mask 0101.
  - Then read, mask 1111 -> 0x11BB33DD.
  - Read the same address, mask 0011 -> 0x000033DD.
- LATENCY=4, back-to-back:
  - Hold i_req_valid for three reads -> o_req_ready low for 3 cycles after each accept.
  - o_rsp_valid pulses at accept+4, +8 and +12.
  - Exactly 3 responses are produced.
- Errors, each with o_err=1, o_rdata=0 and memory unchanged on a later read:
  - Read 0x13 (misaligned).
  - Write 0x400 with ADDR_WIDTH=10 (out of range).
  - Request with ren=wen=1.
  - BASE_ADDR=0x1000, read 0x0FFC (below base, wraps to a large offset).
- Reset mid-BUSY:
  - With LATENCY=4, write 0x30 with 0xCAFEF00D, assert i_rst 2 cycles after accept.
  - Expect: o_rsp_valid stays 0, o_req_ready=1 immediately.
  - A later read of 0x30 returns the prior value, not 0xCAFEF00D.

Source files
------------

// File: rtl/lat_mem.sv
// ---------------------------------------------------------------------------
// lat_mem -- single-port data memory with a valid/ready request handshake,
// configurable access latency and error reporting. Only one request can be
// outstanding at a time.
//
// Parameters
//   ADDR_WIDTH : byte-address bits; the array holds 2**ADDR_WIDTH bytes
//   LATENCY    : cycles from request accept to response (1..8)
//   BASE_ADDR  : first byte address mapped to array byte 0 (word aligned)
//
// Ports
//   i_clk        clock, all state changes on the rising edge
//   i_rst        asynchronous active-high reset
//   i_req_valid  request present
//   o_req_ready  block can accept a request this cycle
//   i_addr       byte address of the access
//   i_ren/i_wen  read / write request
//   i_wdata      write data, lane n = bits [8n+7:8n]
//   i_mask       byte-lane enables, bit n selects byte i_addr+n
//   o_rsp_valid  one-cycle response strobe per accepted request
//   o_rdata      read data, valid with o_rsp_valid
//   o_err        request rejected, valid with o_rsp_valid
// ---------------------------------------------------------------------------
module lat_mem #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          LATENCY    = 1,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_addr,
    input  logic        i_ren,
    input  logic        i_wen,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_mask,
    output logic        o_rsp_valid,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    localparam int         IDX_W    = ADDR_WIDTH - 2;
    localparam int         WORDS    = 2 ** IDX_W;
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;

    // Captured request, used when the access completes after a BUSY phase.
    logic [31:0] cap_addr_reg;
    logic [31:0] cap_wdata_reg;
    logic        cap_ren_reg;
    logic        cap_wen_reg;
    logic [3:0]  cap_mask_reg;

    // Response side state, loaded at the completion edge.
    logic        err_reg;
    logic        rd_ok_reg;
    logic [3:0]  rd_mask_reg;

    logic        accept;
    logic        complete;

    // Request being evaluated at the completion edge: the live inputs when
    // LATENCY==1 (accept and completion share an edge), else the captured copy.
    logic [31:0] ev_addr;
    logic [31:0] ev_wdata;
    logic        ev_ren;
    logic        ev_wen;
    logic [3:0]  ev_mask;

    logic [31:0]      offset;
    logic             req_err;
    logic [IDX_W-1:0] word_idx;
    logic             rd_en;
    logic [3:0]       lane_we;
    logic [7:0]       lane_q [4];

    assign accept      = i_req_valid && (state_reg != BUSY);
    assign o_req_ready = (state_reg != BUSY);
    assign o_rsp_valid = (state_reg == RESP);
    assign o_err       = o_rsp_valid && err_reg;

    assign ev_addr  = (state_reg == BUSY) ? cap_addr_reg  : i_addr;
    assign ev_wdata = (state_reg == BUSY) ? cap_wdata_reg : i_wdata;
    assign ev_ren   = (state_reg == BUSY) ? cap_ren_reg   : i_ren;
    assign ev_wen   = (state_reg == BUSY) ? cap_wen_reg   : i_wen;
    assign ev_mask  = (state_reg == BUSY) ? cap_mask_reg  : i_mask;

    // Addresses below BASE_ADDR wrap to a huge offset and fall out of range.
    // BASE_ADDR is word aligned, so offset[1:0] equals addr[1:0].
    assign offset   = ev_addr - BASE_ADDR;
    assign req_err  = (|offset[31:ADDR_WIDTH]) || (|offset[1:0]) || (ev_ren && ev_wen);
    assign word_idx = offset[ADDR_WIDTH-1:2];

    assign rd_en = complete && ev_ren && !req_err;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        complete   = 1'b0;
        case (state_reg)
            IDLE, RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        complete   = 1'b1;
                    end else begin
                        state_next = BUSY;
                        cnt_next   = LAT_LOAD;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            BUSY: begin
                if (cnt_reg == 4'd1) begin
                    state_next = RESP;
                    cnt_next   = 4'd0;
                    complete   = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, capture and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            cap_addr_reg  <= 32'h0;
            cap_wdata_reg <= 32'h0;
            cap_ren_reg   <= 1'b0;
            cap_wen_reg   <= 1'b0;
            cap_mask_reg  <= 4'h0;
            err_reg       <= 1'b0;
            rd_ok_reg     <= 1'b0;
            rd_mask_reg   <= 4'h0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                cap_addr_reg  <= i_addr;
                cap_wdata_reg <= i_wdata;
                cap_ren_reg   <= i_ren;
                cap_wen_reg   <= i_wen;
                cap_mask_reg  <= i_mask;
            end
            if (complete) begin
                err_reg     <= req_err;
                rd_ok_reg   <= ev_ren && !req_err;
                rd_mask_reg <= ev_mask;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage: one byte-wide bank per lane, word indexed. Accesses are
    // always word aligned, so lane n of a word lives in bank n.
    // Registered read feeds o_rdata during the RESP cycle.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] bank [WORDS];

            assign lane_we[gi] = complete && ev_wen && !req_err && ev_mask[gi];

            always_ff @(posedge i_clk) begin
                if (lane_we[gi]) begin
                    bank[word_idx] <= ev_wdata[8*gi +: 8];
                end
                if (rd_en) begin
                    lane_q[gi] <= bank[word_idx];
                end
            end

            // Unselected lanes, writes, errors and idle cycles read as zero.
            assign o_rdata[8*gi +: 8] =
                (o_rsp_valid && rd_ok_reg && rd_mask_reg[gi]) ? lane_q[gi] : 8'h00;
        end
    endgenerate

endmodule

// File: tb/tb_lat_mem.sv
// ---------------------------------------------------------------------------
// tb_lat_mem -- self-checking bench for lat_mem. Three instances:
//   0: LATENCY=1, BASE_ADDR=0
//   1: LATENCY=4, BASE_ADDR=0
//   2: LATENCY=2, BASE_ADDR=0x1000
// ---------------------------------------------------------------------------
module tb_lat_mem;

    localparam int          NDUT = 3;
    localparam int          LATS  [NDUT] = '{1, 4, 2};
    localparam logic [31:0] BASES [NDUT] = '{32'h0, 32'h0, 32'h1000};

    logic        clk;
    logic        rst       [NDUT];
    logic        req_valid [NDUT];
    logic        ready     [NDUT];
    logic [31:0] addr      [NDUT];
    logic        ren       [NDUT];
    logic        wen       [NDUT];
    logic [31:0] wdata     [NDUT];
    logic [3:0]  mask      [NDUT];
    logic        rsp_valid [NDUT];
    logic [31:0] rdata     [NDUT];
    logic        err       [NDUT];

    int tests = 0;
    int fails = 0;

    genvar gi;
    generate
        for (gi = 0; gi < NDUT; gi++) begin : g_dut
            lat_mem #(
                .ADDR_WIDTH (10),
                .LATENCY    (LATS[gi]),
                .BASE_ADDR  (BASES[gi])
            ) u_dut (
                .i_clk       (clk),
                .i_rst       (rst[gi]),
                .i_req_valid (req_valid[gi]),
                .o_req_ready (ready[gi]),
                .i_addr      (addr[gi]),
                .i_ren       (ren[gi]),
                .i_wen       (wen[gi]),
                .i_wdata     (wdata[gi]),
                .i_mask      (mask[gi]),
                .o_rsp_valid (rsp_valid[gi]),
                .o_rdata     (rdata[gi]),
                .o_err       (err[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          d;
        logic [31:0] a;
        logic        r;
        logic        w;
        logic [31:0] wd;
        logic [3:0]  m;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tv[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Issue one request on instance d and wait (bounded) for its response.
    // lat is the number of cycles after the accept edge until rsp_valid is
    // seen (1 = cycle right after accept); 0 means no response arrived.
    task automatic do_req(input int d, input logic [31:0] a, input logic r, input logic w,
                          input logic [31:0] wd, input logic [3:0] m,
                          output logic [31:0] rd, output logic er, output int lat);
        int guard;
        @(negedge clk);
        addr[d] = a; ren[d] = r; wen[d] = w; wdata[d] = wd; mask[d] = m;
        req_valid[d] = 1'b1;
        guard = 0;
        while (!ready[d] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            fails++;
            tests++;
            $display("FAIL ready_timeout dut%0d: ready stayed 0, required 1", d);
        end
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        rd = 32'h0; er = 1'b0; lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp_valid[d]) begin
                lat = k;
                rd  = rdata[d];
                er  = err[d];
                break;
            end
        end
    endtask

    function automatic void add(input int d, input logic [31:0] a, input logic r, input logic w,
                                input logic [31:0] wd, input logic [3:0] m,
                                input logic [31:0] exp_rd, input logic exp_err);
        vec_t v;
        v.d = d; v.a = a; v.r = r; v.w = w; v.wd = wd; v.m = m;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = LATS[d];
        tv.push_back(v);
    endfunction

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        rdy_prev;
        int          nacc;
        logic [15:0] acc_mask, rsp_mask, rlow_mask;
        logic        seen;

        // ---------------- vector table ----------------
        // LATENCY=1, BASE=0
        add(0, 32'h010, 0, 1, 32'hDEADBEEF, 4'hF, 32'h0,        0);
        add(0, 32'h010, 1, 0, 32'h0,        4'hF, 32'hDEADBEEF, 0);
        add(0, 32'h020, 0, 1, 32'h11223344, 4'hF, 32'h0,        0);
        add(0, 32'h020, 0, 1, 32'hAABBCCDD, 4'h5, 32'h0,        0);
        add(0, 32'h020, 1, 0, 32'h0,        4'hF, 32'h11BB33DD, 0);
        add(0, 32'h020, 1, 0, 32'h0,        4'h3, 32'h000033DD, 0);
        add(0, 32'h000, 0, 1, 32'h55667788, 4'hF, 32'h0,        0);
        add(0, 32'h013, 1, 0, 32'h0,        4'hF, 32'h0,        1);  // misaligned
        add(0, 32'h400, 0, 1, 32'hFFFFFFFF, 4'hF, 32'h0,        1);  // out of range
        add(0, 32'h000, 1, 0, 32'h0,        4'hF, 32'h55667788, 0);  // not aliased
        add(0, 32'h010, 1, 1, 32'h0,        4'hF, 32'h0,        1);  // ren & wen
        add(0, 32'h010, 1, 0, 32'h0,        4'hF, 32'hDEADBEEF, 0);
        add(0, 32'h020, 1, 0, 32'h0,        4'h0, 32'h0,        0);  // mask 0 read
        add(0, 32'h020, 0, 1, 32'hFFFFFFFF, 4'h0, 32'h0,        0);  // mask 0 write
        add(0, 32'h020, 1, 0, 32'h0,        4'hF, 32'h11BB33DD, 0);
        add(0, 32'h020, 0, 0, 32'hFFFFFFFF, 4'hF, 32'h0,        0);  // no-op
        add(0, 32'h3FC, 0, 1, 32'h01020304, 4'hF, 32'h0,        0);  // top word
        add(0, 32'h3FC, 1, 0, 32'h0,        4'hF, 32'h01020304, 0);
        add(0, 32'h000, 1, 0, 32'h0,        4'hC, 32'h55660000, 0);
        // LATENCY=4, BASE=0
        add(1, 32'h030, 0, 1, 32'h12345678, 4'hF, 32'h0,        0);
        add(1, 32'h030, 1, 0, 32'h0,        4'hF, 32'h12345678, 0);
        // LATENCY=2, BASE=0x1000
        add(2, 32'h1000, 0, 1, 32'hCAFEBABE, 4'hF, 32'h0,        0);
        add(2, 32'h1000, 1, 0, 32'h0,        4'hF, 32'hCAFEBABE, 0);
        add(2, 32'h0FFC, 1, 0, 32'h0,        4'hF, 32'h0,        1);  // below base
        add(2, 32'h1400, 0, 1, 32'h99999999, 4'hF, 32'h0,        1);  // past top
        add(2, 32'h13FC, 0, 1, 32'hA5A5A5A5, 4'hF, 32'h0,        0);
        add(2, 32'h13FC, 1, 0, 32'h0,        4'hF, 32'hA5A5A5A5, 0);
        add(2, 32'h1002, 1, 0, 32'h0,        4'hF, 32'h0,        1);  // misaligned
        add(2, 32'h1000, 1, 0, 32'h0,        4'hF, 32'hCAFEBABE, 0);

        // ---------------- reset ----------------
        for (int d = 0; d < NDUT; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; addr[d] = 32'h0; ren[d] = 1'b0;
            wen[d] = 1'b0; wdata[d] = 32'h0; mask[d] = 4'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("reset_ready_dut%0d", d), {31'h0, ready[d]}, 32'h1);
            check($sformatf("reset_rsp_valid_dut%0d", d), {31'h0, rsp_valid[d]}, 32'h0);
            check($sformatf("reset_rdata_dut%0d", d), rdata[d], 32'h0);
            check($sformatf("reset_err_dut%0d", d), {31'h0, err[d]}, 32'h0);
            rst[d] = 1'b0;
        end
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("post_reset_ready_dut%0d", d), {31'h0, ready[d]}, 32'h1);
            check($sformatf("post_reset_rsp_valid_dut%0d", d), {31'h0, rsp_valid[d]}, 32'h0);
        end

        // ---------------- table-driven vectors ----------------
        foreach (tv[i]) begin
            do_req(tv[i].d, tv[i].a, tv[i].r, tv[i].w, tv[i].wd, tv[i].m, rd, er, lat);
            $display("[TB] vec %0d dut%0d addr=%h ren=%b wen=%b mask=%b -> rdata=%h err=%b lat=%0d",
                     i, tv[i].d, tv[i].a, tv[i].r, tv[i].w, tv[i].m, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, tv[i].exp_rd);
            check($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, tv[i].exp_err});
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(tv[i].exp_lat));
        end

        // ---------------- LATENCY=4 back-to-back reads ----------------
        @(negedge clk);
        addr[1] = 32'h030; ren[1] = 1'b1; wen[1] = 1'b0; mask[1] = 4'hF; wdata[1] = 32'h0;
        req_valid[1] = 1'b1;
        rdy_prev  = ready[1];
        nacc      = 0;
        acc_mask  = 16'h0;
        rsp_mask  = 16'h0;
        rlow_mask = 16'h0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            if (req_valid[1] && rdy_prev) begin
                acc_mask[c] = 1'b1;
                nacc++;
                if (nacc == 3) #1 req_valid[1] = 1'b0;
            end
            @(negedge clk);
            rdy_prev = ready[1];
            if (!ready[1]) rlow_mask[c] = 1'b1;
            if (rsp_valid[1]) begin
                rsp_mask[c] = 1'b1;
                check($sformatf("b2b_rdata_cycle%0d", c), rdata[1], 32'h12345678);
            end
        end
        $display("[TB] b2b accepts=%h responses=%h ready_low=%h", acc_mask, rsp_mask, rlow_mask);
        check("b2b_accept_cycles", {16'h0, acc_mask}, 32'h0111);
        check("b2b_response_cycles", {16'h0, rsp_mask}, 32'h0888);
        check("b2b_ready_low_cycles", {16'h0, rlow_mask}, 32'h0777);
        check("b2b_response_count", 32'($countones(rsp_mask)), 32'd3);

        // ---------------- reset mid-BUSY ----------------
        @(negedge clk);
        addr[1] = 32'h030; ren[1] = 1'b0; wen[1] = 1'b1; wdata[1] = 32'hCAFEF00D; mask[1] = 4'hF;
        req_valid[1] = 1'b1;
        @(posedge clk);                 // accept edge
        #1 req_valid[1] = 1'b0;
        check("rst_busy_ready_low", {31'h0, ready[1]}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst[1] = 1'b1;
        #1;
        check("rst_busy_ready_now", {31'h0, ready[1]}, 32'h1);
        check("rst_busy_rsp_valid_now", {31'h0, rsp_valid[1]}, 32'h0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid[1]) seen = 1'b1;
        end
        rst[1] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid[1]) seen = 1'b1;
        end
        $display("[TB] reset mid-BUSY: spurious response seen=%b", seen);
        check("rst_busy_no_response", {31'h0, seen}, 32'h0);
        do_req(1, 32'h030, 1, 0, 32'h0, 4'hF, rd, er, lat);
        $display("[TB] read after reset addr=030 -> rdata=%h err=%b lat=%0d", rd, er, lat);
        check("rst_busy_old_data", rd, 32'h12345678);
        check("rst_busy_read_err", {31'h0, er}, 32'h0);
        check("rst_busy_read_latency", 32'(lat), 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
